// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared definitions for ROB misprediction recovery: busy-table state encoding
// and default sizing.
package rob_recovery_ctrl_pkg;

  localparam int PRF_WIDTH         = 6;
  localparam int ROB_DEPTH_DEFAULT = 32;

  // Encoding is consumed directly by the rename busy table.
  typedef enum logic [1:0] {
    ROB_IDLE     = 2'd0,
    ROB_ROLLBACK = 2'd1,
    ROB_WALK     = 2'd2
  } rob_state_e;

endpackage

// File: rtl/rob_recovery_ctrl.sv
// Misprediction recovery sequencer: one ROLLBACK cycle clears the busy table,
// then a two-entries-per-cycle WALK re-marks surviving, incomplete destinations.
module rob_recovery_ctrl
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_valid,
  input  logic [ROB_IDX_W:0]   flush_rob_ptr,
  input  logic [ROB_IDX_W:0]   rob_head_ptr,
  output logic [ROB_IDX_W-1:0] walk_rd_idx0,
  output logic [ROB_IDX_W-1:0] walk_rd_idx1,
  input  logic                 rob_rd0_rd_en,
  input  logic [PRF_WIDTH-1:0] rob_rd0_prd,
  input  logic                 rob_rd0_complete,
  input  logic                 rob_rd1_rd_en,
  input  logic [PRF_WIDTH-1:0] rob_rd1_prd,
  input  logic                 rob_rd1_complete,
  output logic [1:0]           rob_state,
  output logic                 rob_walk0_valid,
  output logic [PRF_WIDTH-1:0] rob_walk0_prd,
  output logic                 rob_walk0_complete,
  output logic                 rob_walk1_valid,
  output logic [PRF_WIDTH-1:0] rob_walk1_prd,
  output logic                 rob_walk1_complete,
  output logic                 recovery_stall,
  output logic                 walk_done
);

  localparam logic [1:0] ST_IDLE     = ROB_IDLE;
  localparam logic [1:0] ST_ROLLBACK = ROB_ROLLBACK;
  localparam logic [1:0] ST_WALK     = ROB_WALK;

  localparam logic [ROB_IDX_W:0] ONE = (ROB_IDX_W+1)'(1);
  localparam logic [ROB_IDX_W:0] TWO = (ROB_IDX_W+1)'(2);

  logic [1:0]         state;
  logic [ROB_IDX_W:0] walk_ptr;
  logic [ROB_IDX_W:0] remaining;
  logic [ROB_IDX_W:0] step;
  logic [ROB_IDX_W:0] walk_ptr_p1;
  logic               in_walk;
  logic               last_walk;

  always_comb begin
    in_walk     = (state == ST_WALK);
    step        = (remaining >= TWO) ? TWO : remaining;
    last_walk   = in_walk && (remaining <= TWO);
    walk_ptr_p1 = walk_ptr + ONE;
  end

  // Remaining carries the wrap bit so a completely full ROB (N = ROB_DEPTH) fits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      walk_ptr  <= '0;
      remaining <= '0;
    end else if (flush_valid) begin
      // A flush in any state (including a nested one) restarts recovery.
      state     <= ST_ROLLBACK;
      walk_ptr  <= rob_head_ptr;
      remaining <= (flush_rob_ptr - rob_head_ptr) + ONE;
    end else begin
      case (state)
        ST_ROLLBACK: state <= ST_WALK;
        ST_WALK: begin
          walk_ptr  <= walk_ptr + step;
          remaining <= remaining - step;
          if (last_walk) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rob_state          = state;
    recovery_stall     = (state != ST_IDLE);
    walk_done          = last_walk && !flush_valid;
    walk_rd_idx0       = '0;
    walk_rd_idx1       = '0;
    rob_walk0_valid    = 1'b0;
    rob_walk0_prd      = '0;
    rob_walk0_complete = 1'b0;
    rob_walk1_valid    = 1'b0;
    rob_walk1_prd      = '0;
    rob_walk1_complete = 1'b0;
    if (in_walk) begin
      walk_rd_idx0    = walk_ptr[ROB_IDX_W-1:0];
      walk_rd_idx1    = walk_ptr_p1[ROB_IDX_W-1:0];
      rob_walk0_valid = (remaining >= ONE) && rob_rd0_rd_en;
      rob_walk1_valid = (remaining >= TWO) && rob_rd1_rd_en;
    end
    if (rob_walk0_valid) begin
      rob_walk0_prd      = rob_rd0_prd;
      rob_walk0_complete = rob_rd0_complete;
    end
    if (rob_walk1_valid) begin
      rob_walk1_prd      = rob_rd1_prd;
      rob_walk1_complete = rob_rd1_complete;
    end
  end

endmodule
